// File: rtl/rmii_pkg.sv
// -----------------------------------------------------------------------------
// rmii_pkg
// Shared definitions for the RMII/MII frame transmitter:
//   - tx_state_e   : transmitter FSM states
//   - preamble/SFD nibble constants and preamble length
//   - CRC-32 polynomial (reflected) and initial value
//   - fcs_nibble() : selects nibble idx of the complemented CRC, LS nibble first
// Optional feature macro used by the transmitter: RMII_TX_FCS_EN.
// -----------------------------------------------------------------------------
package rmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_ABORT
    } tx_state_e;

    localparam logic [3:0]  C_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  C_SFD_NIB      = 4'hD;
    localparam int          C_PREAMBLE_LEN = 16;

    localparam logic [31:0] C_CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] C_CRC_INIT     = 32'hFFFFFFFF;

    // The FCS goes out as the one's complement of the running CRC,
    // least-significant nibble first.
    function automatic logic [3:0] fcs_nibble(input logic [31:0] crc,
                                              input logic [2:0]  idx);
        logic [31:0] fcs;
        fcs = ~crc;
        return fcs[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/rmii_tx_if.sv
// -----------------------------------------------------------------------------
// rmii_tx_if
// Payload byte stream into the transmitter (valid/ready).
//   s_byte      : payload byte
//   s_byte_vld  : s_byte valid
//   s_byte_last : final payload byte of the frame, qualified by s_byte_vld
//   s_byte_rdy  : transmitter takes the byte when s_byte_vld & s_byte_rdy
// Modports: master = upstream byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface rmii_tx_if;

    logic [7:0] s_byte;
    logic       s_byte_vld;
    logic       s_byte_last;
    logic       s_byte_rdy;

    modport master (
        output s_byte,
        output s_byte_vld,
        output s_byte_last,
        input  s_byte_rdy
    );

    modport slave (
        input  s_byte,
        input  s_byte_vld,
        input  s_byte_last,
        output s_byte_rdy
    );

endinterface

// File: rtl/rmii_tx_crc32_nibble.sv
// -----------------------------------------------------------------------------
// crc32_nibble
// Combinational next-state of the reflected Ethernet CRC-32 for one nibble.
//   crc_in_i  [31:0] : current CRC register
//   nib_i     [3:0]  : nibble as it goes on the wire (LS bit first)
//   crc_out_o [31:0] : CRC after absorbing nib_i
// -----------------------------------------------------------------------------
module crc32_nibble
    import rmii_pkg::*;
(
    input  logic [31:0] crc_in_i,
    input  logic [3:0]  nib_i,
    output logic [31:0] crc_out_o
);

    logic [31:0] crc_v;

    // Four serial LFSR steps, unrolled; the nibble's bits enter LS bit first.
    always_comb begin
        crc_v = crc_in_i ^ {28'd0, nib_i};
        for (int b = 0; b < 4; b++) begin
            crc_v = crc_v[0] ? ((crc_v >> 1) ^ C_CRC_POLY) : (crc_v >> 1);
        end
        crc_out_o = crc_v;
    end

endmodule

// File: rtl/rmii_tx.sv
// -----------------------------------------------------------------------------
// rmii_tx
// MII/RMII-side frame transmitter. Takes payload bytes (DA through end of
// payload) and drives one nibble per tx_clk to the PHY, LS nibble first,
// adding preamble+SFD, zero padding to P_MIN_BYTES and the inter-frame gap.
//
// Optional feature: define RMII_TX_FCS_EN to append a CRC-32 FCS computed
// over payload and pad. Without it, upstream supplies the FCS as payload.
//
// Ports:
//   tx_clk      in   transmit clock, one nibble per cycle
//   tx_rst      in   synchronous active-high reset
//   s_if        slave byte stream (s_byte/s_byte_vld/s_byte_last/s_byte_rdy)
//   tx_data     out  nibble to PHY (registered)
//   tx_en       out  transmit enable (registered)
//   tx_er       out  transmit error, high only on an aborted frame's last cycle
//   tx_busy     out  high in every state except IDLE
//   tx_done     out  pulse on the final tx_en cycle of a completed frame
//   tx_underrun out  pulse on the abort cycle of an underrun frame
// -----------------------------------------------------------------------------
module rmii_tx
    import rmii_pkg::*;
#(
    parameter int P_MIN_BYTES = 60,
    parameter int P_IFG_NIB   = 24
) (
    input  logic       tx_clk,
    input  logic       tx_rst,
    rmii_tx_if.slave   s_if,
    output logic [3:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam int BC_W  = $clog2(P_MIN_BYTES + 1);
    localparam int CNT_W = $clog2(P_IFG_NIB + C_PREAMBLE_LEN + 8);

`ifdef RMII_TX_FCS_EN
    localparam bit HAS_FCS = 1'b1;
`else
    localparam bit HAS_FCS = 1'b0;
`endif

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BC_W-1:0]  byte_cnt_q;
    logic             phase_q;
    logic [7:0]       byte_q;
    logic             last_q;

    logic [3:0]       tx_data_q;
    logic             tx_en_q;
    logic             tx_er_q;
    logic             tx_done_q;
    logic             tx_underrun_q;

    logic             rdy_d;
    logic [BC_W-1:0]  bc_inc_d;
    logic             bc_full_d;
    logic             ifg_end_d;
    logic             start_d;

    // Ready is a decode of registered state, so it lines up with the nibble
    // currently on the wire: the SFD cycle and each high-nibble cycle.
    always_comb begin
        rdy_d = 1'b0;
        case (state_q)
            ST_PREAMBLE: rdy_d = (cnt_q == CNT_W'(C_PREAMBLE_LEN - 1));
            ST_DATA:     rdy_d = phase_q & ~last_q;
            default:     rdy_d = 1'b0;
        endcase
    end

    assign s_if.s_byte_rdy = rdy_d;

    // Byte count after the byte/pad byte now on the wire, saturating.
    assign bc_inc_d  = (byte_cnt_q == BC_W'(P_MIN_BYTES)) ? byte_cnt_q
                                                          : byte_cnt_q + 1'b1;
    assign bc_full_d = (bc_inc_d == BC_W'(P_MIN_BYTES));

    assign ifg_end_d = (state_q == ST_IFG) && (cnt_q == CNT_W'(P_IFG_NIB - 1));

    // A frame starts from IDLE, or straight out of the last IFG cycle so that
    // back-to-back frames see exactly P_IFG_NIB idle nibbles.
    assign start_d = s_if.s_byte_vld && ((state_q == ST_IDLE) || ifg_end_d);

`ifdef RMII_TX_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] crc_nxt;

    // The CRC absorbs the nibble currently on the wire; crc_nxt therefore
    // already covers the final payload/pad nibble when the FCS starts.
    crc32_nibble u_crc (
        .crc_in_i  (crc_q),
        .nib_i     (tx_data_q),
        .crc_out_o (crc_nxt)
    );

    always_ff @(posedge tx_clk) begin
        if (start_d) begin
            crc_q <= C_CRC_INIT;
        end else if ((state_q == ST_DATA) || (state_q == ST_PAD)) begin
            crc_q <= crc_nxt;
        end
    end
`endif

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            byte_cnt_q    <= '0;
            phase_q       <= 1'b0;
            byte_q        <= '0;
            last_q        <= 1'b0;
            tx_data_q     <= 4'h0;
            tx_en_q       <= 1'b0;
            tx_er_q       <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            tx_done_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
            tx_er_q       <= 1'b0;

            if (start_d) begin
                state_q    <= ST_PREAMBLE;
                cnt_q      <= '0;
                byte_cnt_q <= '0;
                phase_q    <= 1'b0;
                tx_en_q    <= 1'b1;
                tx_data_q  <= C_PREAMBLE_NIB;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        tx_en_q   <= 1'b0;
                        tx_data_q <= 4'h0;
                    end

                    ST_PREAMBLE: begin
                        if (cnt_q == CNT_W'(C_PREAMBLE_LEN - 1)) begin
                            if (s_if.s_byte_vld) begin
                                byte_q    <= s_if.s_byte;
                                last_q    <= s_if.s_byte_last;
                                phase_q   <= 1'b0;
                                state_q   <= ST_DATA;
                                tx_data_q <= s_if.s_byte[3:0];
                            end else begin
                                state_q       <= ST_ABORT;
                                tx_data_q     <= 4'h0;
                                tx_er_q       <= 1'b1;
                                tx_underrun_q <= 1'b1;
                            end
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            tx_data_q <= (cnt_q == CNT_W'(C_PREAMBLE_LEN - 2))
                                         ? C_SFD_NIB : C_PREAMBLE_NIB;
                        end
                    end

                    ST_DATA: begin
                        if (!phase_q) begin
                            phase_q   <= 1'b1;
                            tx_data_q <= byte_q[7:4];
                            tx_done_q <= !HAS_FCS && last_q && bc_full_d;
                        end else begin
                            byte_cnt_q <= bc_inc_d;
                            if (!last_q) begin
                                if (s_if.s_byte_vld) begin
                                    byte_q    <= s_if.s_byte;
                                    last_q    <= s_if.s_byte_last;
                                    phase_q   <= 1'b0;
                                    tx_data_q <= s_if.s_byte[3:0];
                                end else begin
                                    state_q       <= ST_ABORT;
                                    tx_data_q     <= 4'h0;
                                    tx_er_q       <= 1'b1;
                                    tx_underrun_q <= 1'b1;
                                end
                            end else if (!bc_full_d) begin
                                state_q   <= ST_PAD;
                                phase_q   <= 1'b0;
                                tx_data_q <= 4'h0;
                            end else begin
`ifdef RMII_TX_FCS_EN
                                state_q   <= ST_FCS;
                                cnt_q     <= '0;
                                tx_data_q <= fcs_nibble(crc_nxt, 3'd0);
`else
                                state_q   <= ST_IFG;
                                cnt_q     <= '0;
                                tx_en_q   <= 1'b0;
                                tx_data_q <= 4'h0;
`endif
                            end
                        end
                    end

                    ST_PAD: begin
                        tx_data_q <= 4'h0;
                        if (!phase_q) begin
                            phase_q   <= 1'b1;
                            tx_done_q <= !HAS_FCS && bc_full_d;
                        end else begin
                            byte_cnt_q <= bc_inc_d;
                            phase_q    <= 1'b0;
                            if (bc_full_d) begin
`ifdef RMII_TX_FCS_EN
                                state_q   <= ST_FCS;
                                cnt_q     <= '0;
                                tx_data_q <= fcs_nibble(crc_nxt, 3'd0);
`else
                                state_q   <= ST_IFG;
                                cnt_q     <= '0;
                                tx_en_q   <= 1'b0;
`endif
                            end
                        end
                    end

`ifdef RMII_TX_FCS_EN
                    ST_FCS: begin
                        if (cnt_q == CNT_W'(7)) begin
                            state_q   <= ST_IFG;
                            cnt_q     <= '0;
                            tx_en_q   <= 1'b0;
                            tx_data_q <= 4'h0;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            tx_data_q <= fcs_nibble(crc_q, cnt_q[2:0] + 3'd1);
                            tx_done_q <= (cnt_q == CNT_W'(6));
                        end
                    end
`endif

                    ST_ABORT: begin
                        state_q   <= ST_IFG;
                        cnt_q     <= '0;
                        tx_en_q   <= 1'b0;
                        tx_data_q <= 4'h0;
                    end

                    ST_IFG: begin
                        tx_en_q   <= 1'b0;
                        tx_data_q <= 4'h0;
                        if (ifg_end_d) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

                    default: begin
                        state_q   <= ST_IDLE;
                        tx_en_q   <= 1'b0;
                        tx_data_q <= 4'h0;
                    end
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_en       = tx_en_q;
    assign tx_er       = tx_er_q;
    assign tx_done     = tx_done_q;
    assign tx_underrun = tx_underrun_q;
    assign tx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rmii_tx.sv
// -----------------------------------------------------------------------------
// tb_rmii_tx
// Scoreboard bench for rmii_tx. The stimulus side builds each frame's
// expected on-wire nibble list from the frame rules (preamble, payload nibbles,
// zero pad, optional FCS from a bytewise CRC) and queues it; a monitor pops
// one entry per tx_en-high cycle and checks the inter-frame gap length.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rmii_tx;

    localparam int P_MIN = 60;
    localparam int P_IFG = 24;

    typedef struct packed {
        logic [3:0] d;
        logic       er;
        logic       done;
        logic       und;
        logic       rdy;
    } exp_t;

    logic       tx_clk = 1'b0;
    logic       tx_rst = 1'b1;
    logic       rst_d  = 1'b1;
    logic [3:0] tx_data;
    logic       tx_en, tx_er, tx_busy, tx_done, tx_underrun;

    rmii_tx_if bif ();

    rmii_tx #(.P_MIN_BYTES(P_MIN), .P_IFG_NIB(P_IFG)) dut (
        .tx_clk      (tx_clk),
        .tx_rst      (tx_rst),
        .s_if        (bif),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_er       (tx_er),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun)
    );

    logic [31:0] c_in;
    logic [3:0]  c_nib;
    logic [31:0] c_out;

    crc32_nibble u_crc_chk (
        .crc_in_i  (c_in),
        .nib_i     (c_nib),
        .crc_out_o (c_out)
    );

    always #5 tx_clk = ~tx_clk;
    always @(posedge tx_clk) rst_d <= tx_rst;

    int         n_vec = 0;
    int         n_err = 0;
    exp_t       exp_q[$];
    logic [7:0] frm[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference CRC: classic bit-serial reflected CRC-32 over whole bytes.
    function automatic logic [31:0] crc_bytes(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Expected wire contents for frm. abort_at >= 0: the source fails to
    // deliver byte abort_at, so the frame ends with one error nibble.
    task automatic push_frame(input int abort_at);
        logic [3:0] nib[$];
        bit         rq[$];
        logic [7:0] body[$];
        logic [31:0] fcs;
        int n;
        exp_t e;
        n = frm.size();
        for (int i = 0; i < 15; i++) begin nib.push_back(4'h5); rq.push_back(1'b0); end
        nib.push_back(4'hD); rq.push_back(1'b1);
        if (abort_at >= 0) begin
            for (int i = 0; i < abort_at; i++) begin
                nib.push_back(frm[i][3:0]); rq.push_back(1'b0);
                nib.push_back(frm[i][7:4]); rq.push_back(1'b1);
            end
            foreach (nib[i]) begin
                e = '{d: nib[i], er: 1'b0, done: 1'b0, und: 1'b0, rdy: rq[i]};
                exp_q.push_back(e);
            end
            e = '{d: 4'h0, er: 1'b1, done: 1'b0, und: 1'b1, rdy: 1'b0};
            exp_q.push_back(e);
            return;
        end
        body = frm;
        while (body.size() < P_MIN) body.push_back(8'h00);
        foreach (body[i]) begin
            nib.push_back(body[i][3:0]); rq.push_back(1'b0);
            nib.push_back(body[i][7:4]); rq.push_back(i < n - 1);
        end
`ifdef RMII_TX_FCS_EN
        fcs = ~crc_bytes(body);
        for (int k = 0; k < 8; k++) begin
            nib.push_back(fcs[4*k +: 4]); rq.push_back(1'b0);
        end
`else
        fcs = 32'd0;
`endif
        foreach (nib[i]) begin
            e = '{d: nib[i], er: 1'b0, done: (i == nib.size() - 1), und: 1'b0, rdy: rq[i]};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge tx_clk);
            if (bif.s_byte_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: s_byte_rdy got 0 expected 1 within 400 cycles");
        end
        @(posedge tx_clk); #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge tx_clk);
            if (!tx_busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: tx_busy got 1 expected 0 within 2000 cycles");
        end
        chk("frame_drained(entries_left)", exp_q.size(), 0);
        @(posedge tx_clk); #1;
    endtask

    task automatic send_frame(input int abort_at, input int rst_at, input bit keep_vld);
        int n;
        n = frm.size();
        push_frame(abort_at);
        if (abort_at == 0) begin
            bif.s_byte = frm[0]; bif.s_byte_last = (n == 1); bif.s_byte_vld = 1'b1;
            repeat (3) @(posedge tx_clk);
            #1 bif.s_byte_vld = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                bif.s_byte_vld = 1'b0; bif.s_byte_last = 1'b0;
                break;
            end
            if (i == rst_at) begin
                tx_rst = 1'b1; bif.s_byte_vld = 1'b0; bif.s_byte_last = 1'b0;
                @(posedge tx_clk); #1;
                exp_q.delete();
                @(posedge tx_clk); #1 tx_rst = 1'b0;
                return;
            end
            bif.s_byte = frm[i]; bif.s_byte_last = (i == n - 1); bif.s_byte_vld = 1'b1;
            wait_accept();
        end
        if (!keep_vld) begin
            bif.s_byte_vld = 1'b0; bif.s_byte_last = 1'b0;
            wait_idle();
        end
    endtask

    task automatic rand_frame(input int len);
        frm.delete();
        for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    endtask

    // Monitor: one scoreboard entry per tx_en-high cycle, quiet flags
    // otherwise, and the length of every gap that follows a frame.
    initial begin
        bit   prev_en;
        bit   in_gap;
        int   gap;
        exp_t e;
        prev_en = 1'b0; in_gap = 1'b0; gap = 0;
        forever begin
            @(negedge tx_clk);
            if (rst_d) begin
                prev_en = 1'b0; in_gap = 1'b0; gap = 0;
                chk("reset_outputs{data,en,er,busy,done,und,rdy}",
                    {tx_data, tx_en, tx_er, tx_busy, tx_done, tx_underrun, bif.s_byte_rdy}, 32'd0);
            end else begin
                if (tx_en) begin
                    if (in_gap) begin chk("ifg_len", gap, P_IFG); in_gap = 1'b0; end
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_nibble: tx_en got 1 (tx_data=0x%0h) expected 0", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("nibble{data,er,done,und,rdy}",
                            {tx_data, tx_er, tx_done, tx_underrun, bif.s_byte_rdy}, 32'(e));
                    end
                end else begin
                    chk("idle_flags{er,done,und,rdy}",
                        {tx_er, tx_done, tx_underrun, bif.s_byte_rdy}, 32'd0);
                    if (prev_en) begin in_gap = 1'b1; gap = 0; end
                    if (in_gap) begin
                        if (tx_busy) gap++;
                        else begin chk("ifg_len", gap, P_IFG); in_gap = 1'b0; end
                    end
                end
                prev_en = tx_en;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ascii[9];
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        bif.s_byte = 8'h00; bif.s_byte_vld = 1'b0; bif.s_byte_last = 1'b0;

        // Standalone nibble CRC over "123456789", low nibble first.
        c_in = 32'hFFFFFFFF; c_nib = 4'h0;
        for (int i = 0; i < 9; i++) begin
            c_nib = ascii[i][3:0]; #1; c_in = c_out;
            c_nib = ascii[i][7:4]; #1; c_in = c_out;
        end
        chk("crc32_check_value", ~c_in, 32'hCBF43926);

        repeat (3) @(posedge tx_clk);
        #1 tx_rst = 1'b0;
        repeat (2) @(posedge tx_clk);
        #1;

        // 64 counting bytes: no pad needed.
        frm.delete();
        for (int i = 0; i < 64; i++) frm.push_back(8'(i));
        send_frame(-1, -1, 1'b0);

        // Short frame padded to the minimum.
        rand_frame(10);
        send_frame(-1, -1, 1'b0);

        // Exactly minimum length.
        rand_frame(P_MIN);
        send_frame(-1, -1, 1'b0);

        // Random lengths either side of the minimum, including one byte.
        rand_frame(1);
        send_frame(-1, -1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            rand_frame($urandom_range(2, 90));
            send_frame(-1, -1, 1'b0);
        end

        // Underrun mid-payload and at the SFD.
        rand_frame(12);
        send_frame(5, -1, 1'b0);
        rand_frame(8);
        send_frame(0, -1, 1'b0);

        // Back-to-back frames with valid held high throughout.
        rand_frame(P_MIN);
        send_frame(-1, -1, 1'b1);
        rand_frame(P_MIN);
        send_frame(-1, -1, 1'b0);

        // Reset mid-payload, then a clean frame afterwards.
        rand_frame(40);
        send_frame(-1, 20, 1'b0);
        repeat (2) @(posedge tx_clk);
        #1;
        rand_frame(15);
        send_frame(-1, -1, 1'b0);

        repeat (5) @(posedge tx_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
